// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache access controller: held request/handshake, pipeline stall, sticky status.
// Define MEM_ACCESS_LLSC_EN to enable the load-linked/store-conditional link register.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_in,
  input  logic        memRd_in,
  input  logic        memWr_in,
  input  logic        ll_in,
  input  logic        sc_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] storeData_in,
  input  logic        halt_in,
  input  logic        flush_in,
  input  logic        snoopInv_in,
  input  logic [31:0] snoopAddr_in,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic [31:0] dmemload_out,
  output logic        mem_done,
  output logic        stall_out,
  output logic        sc_result,
  output logic        halt_out,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        is_load_q, is_sc_q;
  logic [31:0] addr_q, data_q, load_q;
  logic [7:0]  cnt_q;
  logic        done_q, sc_res_q, halt_q, misalign_q, timeout_q;

  logic accept, req_load, req_mem, req_sc, aligned, sc_ok, start;

  assign accept   = (state_q == IDLE) && valid_in && !flush_in && !halt_q;
  assign req_load = memRd_in || ll_in;
  assign req_mem  = req_load || memWr_in || sc_in;
  assign req_sc   = sc_in && !req_load;
  assign aligned  = (addr_in[1:0] == 2'b00);
  assign start    = accept && !halt_in && req_mem && aligned && !(req_sc && !sc_ok);

`ifdef MEM_ACCESS_LLSC_EN
  logic        link_valid_q, is_ll_q, snoop_hit, sc_reject;
  logic [31:0] link_addr_q;

  assign snoop_hit = snoopInv_in && (snoopAddr_in == link_addr_q);
  assign sc_ok     = link_valid_q && (addr_in == link_addr_q) && !snoop_hit;
  assign sc_reject = accept && !halt_in && req_mem && aligned && req_sc && !sc_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= 32'h0;
      is_ll_q      <= 1'b0;
    end else begin
      if (start) is_ll_q <= ll_in;
      if (snoop_hit || sc_reject) link_valid_q <= 1'b0;
      // A completing LL re-arms the link; any completing store/SC breaks it.
      if (state_q == ACCESS && dhit) begin
        if (is_ll_q) begin
          link_valid_q <= 1'b1;
          link_addr_q  <= addr_q;
        end else if (!is_load_q) begin
          link_valid_q <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_snoop;
  assign unused_snoop = snoopInv_in ^ (^snoopAddr_in);
  assign sc_ok        = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      is_load_q  <= 1'b0;
      is_sc_q    <= 1'b0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      load_q     <= 32'h0;
      cnt_q      <= 8'h0;
      done_q     <= 1'b0;
      sc_res_q   <= 1'b0;
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      sc_res_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (halt_in) begin
              halt_q <= 1'b1;
              done_q <= 1'b1;
            end else if (!req_mem) begin
              done_q <= 1'b1;
            end else if (!aligned) begin
              misalign_q <= 1'b1;
              done_q     <= 1'b1;
            end else if (!start) begin
              done_q <= 1'b1;
            end else begin
              addr_q    <= addr_in;
              data_q    <= storeData_in;
              is_load_q <= req_load;
              is_sc_q   <= req_sc;
              cnt_q     <= 8'h0;
              state_q   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // dhit takes priority over an expiring counter in the same cycle.
          if (dhit) begin
            if (is_load_q) load_q <= dmemload;
            done_q   <= 1'b1;
            sc_res_q <= is_sc_q;
            state_q  <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            load_q    <= 32'hDEADBEEF;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmemREN      = (state_q == ACCESS) && is_load_q;
  assign dmemWEN      = (state_q == ACCESS) && !is_load_q;
  assign dmemaddr     = addr_q;
  assign dmemstore    = data_q;
  assign stall_out    = (state_q == ACCESS) || start;
  assign dmemload_out = load_q;
  assign mem_done     = done_q;
  assign sc_result    = sc_res_q;
  assign halt_out     = halt_q;
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int T = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        valid_in, memRd_in, memWr_in, ll_in, sc_in, halt_in, flush_in, snoopInv_in;
  logic [31:0] addr_in, storeData_in, snoopAddr_in;
  logic        dmemREN, dmemWEN, dhit;
  logic [31:0] dmemaddr, dmemstore, dmemload, dmemload_out;
  logic        mem_done, stall_out, sc_result, halt_out, misalign_err, timeout_err;

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST), .valid_in(valid_in), .memRd_in(memRd_in), .memWr_in(memWr_in),
    .ll_in(ll_in), .sc_in(sc_in), .addr_in(addr_in), .storeData_in(storeData_in),
    .halt_in(halt_in), .flush_in(flush_in), .snoopInv_in(snoopInv_in), .snoopAddr_in(snoopAddr_in),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .dmemload_out(dmemload_out), .mem_done(mem_done),
    .stall_out(stall_out), .sc_result(sc_result), .halt_out(halt_out),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Reference model state
  logic        m_halt, m_mis, m_to, m_lv;
  logic [31:0] m_dout, m_la;

  logic [31:0] addr_set [4] = '{32'h100, 32'h204, 32'h300, 32'h304};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    valid_in = 0; memRd_in = 0; memWr_in = 0; ll_in = 0; sc_in = 0; halt_in = 0;
    flush_in = 0; snoopInv_in = 0; dhit = 0;
    addr_in = $urandom; storeData_in = $urandom; snoopAddr_in = $urandom; dmemload = $urandom;
  endtask

  task automatic model_reset();
    m_halt = 0; m_mis = 0; m_to = 0; m_lv = 0; m_dout = 32'h0; m_la = 32'h0;
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_halt"}, 32'(halt_out), 32'(m_halt));
    check_eq({tag, "_misalign"}, 32'(misalign_err), 32'(m_mis));
    check_eq({tag, "_timeout"}, 32'(timeout_err), 32'(m_to));
  endtask

  task automatic do_reset();
    idle_in();
    RST = 1;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    model_reset();
    @(negedge CLK);
    check_eq("rst_ren", 32'(dmemREN), 0);
    check_eq("rst_wen", 32'(dmemWEN), 0);
    check_eq("rst_addr", dmemaddr, 0);
    check_eq("rst_store", dmemstore, 0);
    check_eq("rst_dout", dmemload_out, 0);
    check_eq("rst_done", 32'(mem_done), 0);
    check_eq("rst_stall", 32'(stall_out), 0);
    check_eq("rst_sc", 32'(sc_result), 0);
    check_flags("rst");
    @(posedge CLK); #1;
  endtask

  // kind: 0 non-mem, 1 load, 2 store, 3 LL, 4 SC, 5 bubble (valid low), 6 halt
  // k: ACCESS cycle (1 = first) in which dhit is returned; k > T never returns it.
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] sdata,
                         input int k, input logic [31:0] lval, input logic flush,
                         input logic snoop, input logic [31:0] saddr, input logic both);
    logic acc, is_mem, is_load, is_sc, alig, sc_ok, go, exp_sc, fin, hit;
    idle_in();
    valid_in = (kind != 5);
    halt_in = (kind == 6);
    memRd_in = (kind == 1) || (kind == 3);
    memWr_in = (kind == 2) || (kind == 4) || (kind == 1 && both);
    ll_in = (kind == 3);
    sc_in = (kind == 4);
    addr_in = addr; storeData_in = sdata; flush_in = flush;
    snoopInv_in = snoop; snoopAddr_in = saddr;

`ifdef MEM_ACCESS_LLSC_EN
    if (snoop && saddr == m_la) m_lv = 0;
    sc_ok = m_lv && (addr == m_la);
`else
    sc_ok = 1;
`endif
    acc     = (kind != 5) && !flush && !m_halt;
    is_mem  = (kind >= 1) && (kind <= 4);
    is_load = (kind == 1) || (kind == 3);
    is_sc   = (kind == 4);
    alig    = (addr[1:0] == 2'b00);
    go      = acc && kind != 6 && is_mem && alig && (!is_sc || sc_ok);
    exp_sc  = 0;
    if (acc) begin
      if (kind == 6) m_halt = 1;
      else if (is_mem && !alig) m_mis = 1;
      else if (is_sc && !sc_ok) m_lv = 0;
    end

    @(negedge CLK);
    check_eq("acc_stall", 32'(stall_out), 32'(go));
    check_eq("acc_ren", 32'(dmemREN), 0);
    check_eq("acc_wen", 32'(dmemWEN), 0);
    check_eq("acc_done", 32'(mem_done), 0);
    @(posedge CLK); #1;

    if (go) begin
      fin = 0;
      for (int kk = 1; kk <= T && !fin; kk++) begin
        // Garbage on the instruction inputs must not disturb the held request.
        valid_in = $urandom; flush_in = $urandom; memRd_in = $urandom; memWr_in = $urandom;
        ll_in = $urandom; sc_in = $urandom; halt_in = $urandom;
        addr_in = $urandom; storeData_in = $urandom; snoopInv_in = 0;
        hit = (kk == k);
        dhit = hit;
        dmemload = hit ? lval : $urandom;
        @(negedge CLK);
        check_eq("req_ren", 32'(dmemREN), 32'(is_load));
        check_eq("req_wen", 32'(dmemWEN), 32'(!is_load));
        check_eq("req_addr", dmemaddr, addr);
        if (!is_load) check_eq("req_store", dmemstore, sdata);
        check_eq("req_stall", 32'(stall_out), 1);
        check_eq("req_done", 32'(mem_done), 0);
        if (hit) begin
          fin = 1;
          if (is_load) m_dout = lval;
          exp_sc = is_sc;
          if (kind == 3) begin m_lv = 1; m_la = addr; end
          else if (!is_load) m_lv = 0;
        end else if (kk == T) begin
          fin = 1;
          m_to = 1;
          m_dout = 32'hDEADBEEF;
        end
        @(posedge CLK); #1;
      end
    end
    idle_in();
    dhit = $urandom;

    @(negedge CLK);
    check_eq("fin_done", 32'(mem_done), 32'(acc));
    check_eq("fin_dout", dmemload_out, m_dout);
    check_eq("fin_sc", 32'(sc_result), 32'(exp_sc));
    check_eq("fin_ren", 32'(dmemREN), 0);
    check_eq("fin_wen", 32'(dmemWEN), 0);
    check_eq("fin_stall", 32'(stall_out), 0);
    check_flags("fin");
    @(posedge CLK); #1;
    idle_in();
    n_txn++;
    $display("txn %0d kind=%0d addr=%h k=%0d acc=%0d go=%0d sc=%0d dout=%h",
             n_txn, kind, addr, k, acc, go, exp_sc, m_dout);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind, k;
    logic [31:0] a, sa;
    model_reset();
    do_reset();

    run_txn(1, 32'h100, 32'h0, 3, 32'h12345678, 0, 0, 0, 0);       // load, dhit 3rd cycle
    run_txn(2, 32'h204, 32'hCAFEF00D, 2, 32'h0, 0, 0, 0, 0);        // store
    run_txn(1, 32'h204, 32'h0, 1, 32'hA5A5A5A5, 0, 0, 0, 0);        // following load
    run_txn(0, 32'h0, 32'h0, 1, 32'h0, 0, 0, 0, 0);                 // non-memory
    run_txn(1, 32'h100, 32'h0, T, 32'h0BADF00D, 0, 0, 0, 0);        // dhit in expiry cycle
    run_txn(1, 32'h102, 32'h0, 1, 32'h0, 0, 0, 0, 0);               // misaligned
    run_txn(1, 32'h100, 32'h0, 99, 32'h0, 0, 0, 0, 0);              // timeout
    run_txn(1, 32'h100, 32'h0, 1, 32'h11111111, 1, 0, 0, 0);        // flushed
    run_txn(4, 32'h300, 32'h55AA55AA, 1, 32'h0, 0, 0, 0, 0);        // SC without prior LL
`ifdef MEM_ACCESS_LLSC_EN
    run_txn(3, 32'h300, 32'h0, 2, 32'h33333333, 0, 0, 0, 0);
    run_txn(4, 32'h300, 32'h77777777, 1, 32'h0, 0, 0, 0, 0);        // SC succeeds
    run_txn(3, 32'h300, 32'h0, 1, 32'h44444444, 0, 0, 0, 0);
    run_txn(5, 32'h0, 32'h0, 1, 32'h0, 0, 1, 32'h300, 0);           // snoop kills link
    run_txn(4, 32'h300, 32'h88888888, 1, 32'h0, 0, 0, 0, 0);        // SC fails
    run_txn(3, 32'h304, 32'h0, 1, 32'h99999999, 0, 0, 0, 0);
    run_txn(4, 32'h304, 32'h12121212, 1, 32'h0, 0, 1, 32'h304, 0);  // snoop coincides with SC
`endif

    do_reset();
    // Reset while a request is outstanding drops it with no mem_done.
    idle_in();
    valid_in = 1; memRd_in = 1; addr_in = 32'h100;
    @(posedge CLK); #1;
    idle_in();
    @(negedge CLK);
    check_eq("mid_ren", 32'(dmemREN), 1);
    @(posedge CLK); #1;
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    model_reset();
    @(negedge CLK);
    check_eq("mid_ren_off", 32'(dmemREN), 0);
    check_eq("mid_stall", 32'(stall_out), 0);
    check_eq("mid_done", 32'(mem_done), 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_eq("mid_done2", 32'(mem_done), 0);
    @(posedge CLK); #1;

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 5);
      a = addr_set[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      sa = addr_set[$urandom_range(0, 3)];
      k = $urandom_range(1, T + 2);
      run_txn(kind, a, $urandom, k, $urandom, ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0), sa, ($urandom_range(0, 7) == 0));
    end

    run_txn(6, 32'h0, 32'h0, 1, 32'h0, 0, 0, 0, 0);                 // halt
    run_txn(1, 32'h100, 32'h0, 1, 32'hFFFF0000, 0, 0, 0, 0);        // ignored after halt
    run_txn(2, 32'h204, 32'h1, 1, 32'h0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
